lfsr_checker: RTL and testbench

- Serial PRBS receiver/checker: the consuming end of the bit stream produced by the `LFSR` generator block.
- Self-synchronises to an incoming Fibonacci LFSR sequence, declares lock, then counts bit errors against a flywheel prediction.
- Sits at the sink side of a link-test path, driven by the generator output (or the link under test) on the same clock.

---
 rtl/lfsr_checker.sv | 197 +++++++++++++++++++
 tb/tb_lfsr_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Serial PRBS receiver/checker for a Fibonacci LFSR stream.
//   fb = ^(s & TAPS), next s = {s[WIDTH-2:0], fb}, transmitted bit = fb.
// The checker fills its shift register from the line (HUNT), self-synchronises
// while counting consecutive correct predictions (VERIFY), then free-runs on
// its own prediction (LOCKED, flywheel) and counts bit errors.
//
// Optional feature macro: LFSR_CHK_LOSS_EN
//   When defined, a LOCKED checker drops back to HUNT once LOSS_THRESH errors
//   are seen inside one window of LOSS_WIN accepted bits.
//   When undefined, LOCKED is held until reset.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   qualifies in_bit (bit accepted only when 1)
//   in_bit     in   received serial PRBS bit
//   clr_cnt    in   synchronous clear of err_count (wins over an error)
//   locked     out  registered, 1 while in LOCKED
//   err_pulse  out  registered one-cycle pulse per errored bit while locked
//   err_count  out  saturating error count since reset / clr_cnt
//   state_o    out  current state: 0=HUNT, 1=VERIFY, 2=LOCKED
// -----------------------------------------------------------------------------
module lfsr_checker #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] TAPS        = 32'h0000_00B8,
    parameter int          LOCK_COUNT  = 16,
    parameter int          ERR_W       = 16,
    parameter int          LOSS_WIN    = 32,
    parameter int          LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state_o
);

    localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
    localparam int               FILL_W = $clog2(WIDTH + 1);

    if (WIDTH < 3 || WIDTH > 32 || LOCK_COUNT < 1 || LOCK_COUNT > 255 ||
        LOSS_WIN < 1 || LOSS_THRESH < 1) begin : g_param_check
        $error("lfsr_checker: illegal parameter value");
    end

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_sr, w_sr_nxt, w_sr_line;
    logic [FILL_W-1:0]   r_fill, w_fill_nxt;
    logic [7:0]          r_match, w_match_nxt;
    logic                r_locked, r_err_pulse;
    logic [ERR_W-1:0]    r_err_count, w_err_count_nxt;
    logic                w_pred, w_err_bit, w_loss, w_locked_nxt;

    assign w_pred    = ^(r_sr & TAPS_W);
    assign w_sr_line = {r_sr[WIDTH-2:0], in_bit};
    // An error is only meaningful once the flywheel is running.
    assign w_err_bit = in_valid && (r_state == LOCKED) && (in_bit != w_pred);

`ifdef LFSR_CHK_LOSS_EN
    localparam int WIN_W = $clog2(LOSS_WIN + 1);
    localparam int THR_W = $clog2(LOSS_THRESH + 1);

    logic [WIN_W-1:0] r_win_cnt;
    logic [THR_W-1:0] r_win_err;

    // Threshold reached on this bit; takes priority over the window wrap.
    assign w_loss = w_err_bit && (r_win_err == THR_W'(LOSS_THRESH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (r_state != LOCKED || w_loss) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (in_valid) begin
            if (r_win_cnt == WIN_W'(LOSS_WIN - 1)) begin
                r_win_cnt <= '0;
                r_win_err <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                r_win_err <= r_win_err + THR_W'(w_err_bit);
            end
        end
    end
`else
    assign w_loss = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HUNT;
            r_sr    <= '0;
            r_fill  <= '0;
            r_match <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_fill  <= w_fill_nxt;
            r_match <= w_match_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_fill_nxt  = r_fill;
        w_match_nxt = r_match;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    w_sr_nxt = w_sr_line;
                    if (r_fill != FILL_W'(WIDTH))
                        w_fill_nxt = r_fill + 1'b1;
                    // Fill holds at WIDTH, so every later bit re-tests sr.
                    if (r_fill >= FILL_W'(WIDTH - 1) && w_sr_line != '0) begin
                        w_state_nxt = VERIFY;
                        w_match_nxt = '0;
                    end
                end
                VERIFY: begin
                    w_sr_nxt = w_sr_line;
                    if (w_sr_line == '0) begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                    end else if (in_bit == w_pred) begin
                        if (r_match == 8'(LOCK_COUNT - 1)) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                        end else begin
                            w_match_nxt = r_match + 1'b1;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction, not the line, is shifted in.
                    w_sr_nxt = {r_sr[WIDTH-2:0], w_pred};
                    if (w_loss) begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_fill_nxt  = '0;
                    w_match_nxt = '0;
                end
            endcase
        end
    end

    // Output logic (values registered below)
    always_comb begin
        w_locked_nxt    = (w_state_nxt == LOCKED);
        w_err_count_nxt = r_err_count;
        if (clr_cnt)
            w_err_count_nxt = '0;
        else if (w_err_bit && r_err_count != {ERR_W{1'b1}})
            w_err_count_nxt = r_err_count + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_locked    <= w_locked_nxt;
            r_err_pulse <= w_err_bit;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign state_o   = r_state;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
// Self-checking bench for lfsr_checker (WIDTH=8, TAPS=8'hB8, LOCK_COUNT=16,
// ERR_W=4). A software PRBS generator produces the line; the expected
// behaviour is derived from the number of clean accepted bits since the
// checker was reset (lock after WIDTH+LOCK_COUNT) and from the bits the bench
// deliberately inverts once locked.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int LOCK_BITS = 24;
    localparam int CNT_MAX   = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       clr_cnt;
    logic       locked;
    logic       err_pulse;
    logic [3:0] err_count;
    logic [1:0] state_o;

    lfsr_checker #(
        .WIDTH      (8),
        .TAPS       (32'h0000_00B8),
        .LOCK_COUNT (16),
        .ERR_W      (4),
        .LOSS_WIN   (32),
        .LOSS_THRESH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_chk  = 0;
    logic [7:0] g;        // reference generator state
    int         acc;      // clean accepted bits since checker reset / relock
    int         m_cnt;    // expected err_count

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic gen_bit(output logic b);
        b = ^(g & 8'hB8);
        g = {g[6:0], b};
    endtask

    // Present one cycle of input, then sample 1 time unit after the edge.
    task automatic send(input logic v, input logic b, input logic clr);
        in_valid = v;
        in_bit   = b;
        clr_cnt  = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_state(input int a);
        if (a < 8)              return 32'd0;
        else if (a < LOCK_BITS) return 32'd1;
        else                    return 32'd2;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clr_cnt  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        acc   = 0;
        m_cnt = 0;
    endtask

    // Feed LOCK_BITS clean bits from a fresh generator seed.
    task automatic lock_up(input logic [7:0] seed, input string tag);
        logic b;
        g = seed;
        for (int i = 0; i < LOCK_BITS; i++) begin
            gen_bit(b);
            send(1'b1, b, 1'b0);
            acc++;
            check({tag, "_state"}, state_o, exp_state(acc));
            check({tag, "_locked"}, locked, (acc >= LOCK_BITS) ? 1 : 0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic b;
        logic v, clr, inj;
        int   since_err;

        reset = 1'b1;
        in_valid = 1'b0;
        in_bit = 1'b0;
        clr_cnt = 1'b0;
        #1;
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_count", err_count, 0);
        check("rst_state", state_o, 0);
        do_reset();

        // Clean lock from seed 8'h01, then 476 more clean bits
        lock_up(8'h01, "clean");
        for (int i = 0; i < 476; i++) begin
            gen_bit(b);
            send(1'b1, b, 1'b0);
            check("clean_pulse", err_pulse, 0);
        end
        check("clean_count", err_count, 0);
        check("clean_state", state_o, 2);

        // Single inverted bit: one pulse, count 1, flywheel absorbs it
        gen_bit(b);
        send(1'b1, ~b, 1'b0);
        m_cnt = 1;
        check("single_pulse", err_pulse, 1);
        check("single_count", err_count, m_cnt);
        for (int i = 0; i < 50; i++) begin
            gen_bit(b);
            send(1'b1, b, 1'b0);
            check("single_after_pulse", err_pulse, 0);
        end
        check("single_after_count", err_count, 1);

        // Clear coincident with an error: clear wins
        gen_bit(b);
        send(1'b1, ~b, 1'b1);
        m_cnt = 0;
        check("clr_err_count", err_count, 0);
        check("clr_err_pulse", err_pulse, 1);
        gen_bit(b);
        send(1'b1, b, 1'b0);
        check("clr_hold_count", err_count, 0);

        // 20 spaced errors: 4-bit counter saturates at 15
        for (int k = 1; k <= 20; k++) begin
            for (int i = 0; i < 39; i++) begin
                gen_bit(b);
                send(1'b1, b, 1'b0);
            end
            gen_bit(b);
            send(1'b1, ~b, 1'b0);
            m_cnt = sat_inc(m_cnt);
            check("sat_count", err_count, m_cnt);
            check("sat_pulse", err_pulse, 1);
        end
        check("sat_locked", locked, 1);

        // Asynchronous reset mid-LOCKED
        #2 reset = 1'b1;
        #1;
        check("midrst_locked", locked, 0);
        check("midrst_pulse", err_pulse, 0);
        check("midrst_count", err_count, 0);
        check("midrst_state", state_o, 0);
        @(negedge clk);
        reset = 1'b0;
        acc = 0;
        m_cnt = 0;

        // Gapped valid 1,0,0,1 with garbage on idle cycles
        g = 8'($urandom_range(255, 1));
        for (int i = 0; acc < LOCK_BITS + 4 && i < 400; i++) begin
            v = (i % 4 == 0) || (i % 4 == 3);
            if (v) begin
                gen_bit(b);
                send(1'b1, b, 1'b0);
                acc++;
            end else begin
                send(1'b0, 1'($urandom), 1'b0);
                check("gap_idle_pulse", err_pulse, 0);
            end
            check("gap_state", state_o, exp_state(acc));
            check("gap_locked", locked, (acc >= LOCK_BITS) ? 1 : 0);
        end
        check("gap_count", err_count, 0);

        // All-zero stream never leaves HUNT
        do_reset();
        for (int i = 0; i < 100; i++) begin
            send(1'b1, 1'b0, 1'b0);
            check("zero_state", state_o, 0);
            check("zero_locked", locked, 0);
        end

`ifdef LFSR_CHK_LOSS_EN
        // 4 errors in the first window after lock force relock
        do_reset();
        lock_up(8'($urandom_range(255, 1)), "loss_lock");
        for (int j = 0; j < 7; j++) begin
            gen_bit(b);
            inj = (j % 2 == 0);
            send(1'b1, b ^ inj, 1'b0);
            if (inj) m_cnt = sat_inc(m_cnt);
            check("loss_pulse", err_pulse, inj);
            check("loss_state", state_o, (j == 6) ? 0 : 2);
            check("loss_locked", locked, (j == 6) ? 0 : 1);
        end
        check("loss_count", err_count, 4);
        acc = 0;
        for (int i = 0; i < LOCK_BITS; i++) begin
            gen_bit(b);
            send(1'b1, b, 1'b0);
            acc++;
            check("relock_state", state_o, exp_state(acc));
            check("relock_locked", locked, (acc >= LOCK_BITS) ? 1 : 0);
        end
        check("relock_count", err_count, 4);
`endif

        // Randomized traffic: gaps, sparse injected errors, occasional clears
        do_reset();
        g = 8'($urandom_range(255, 1));
        since_err = 1000;
        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(3) != 0);
            clr = ($urandom_range(99) == 0);
            inj = 1'b0;
            if (v) begin
                gen_bit(b);
                if (acc >= LOCK_BITS && since_err >= 40 && $urandom_range(9) == 0)
                    inj = 1'b1;
                since_err = inj ? 0 : since_err + 1;
                acc++;
            end else begin
                b = 1'($urandom);
            end
            if (clr)      m_cnt = 0;
            else if (inj) m_cnt = sat_inc(m_cnt);
            send(v, b ^ inj, clr);
            check("rnd_pulse", err_pulse, inj);
            check("rnd_count", err_count, m_cnt);
            check("rnd_state", state_o, exp_state(acc));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
